// File: rtl/tensor_stream_serializer.sv
// tensor_stream_serializer: captures a parallel H x W x C tensor and streams it
// out element by element in raster order. Optional SER_EOL_EN adds m_eol.
module tensor_stream_serializer #(
    parameter int CHANNELS   = 1,
    parameter int HEIGHT     = 2,
    parameter int WIDTH      = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_in [0:HEIGHT-1][0:WIDTH-1][0:CHANNELS-1],
    output logic                         in_ready,
    output logic                         frame_drop,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic                         m_first,
    output logic                         m_last
`ifdef SER_EOL_EN
    ,
    output logic                         m_eol
`endif
);

    localparam int HW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int WW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [HW-1:0] H_MAX = HW'(HEIGHT - 1);
    localparam logic [WW-1:0] W_MAX = WW'(WIDTH - 1);
    localparam logic [CW-1:0] C_MAX = CW'(CHANNELS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [WW-1:0] w_q, w_d;
    logic [CW-1:0] c_q, c_d;
    logic          drop_q, drop_d;
    logic          cap_en;

    logic signed [DATA_WIDTH-1:0] cap_q [0:HEIGHT-1][0:WIDTH-1][0:CHANNELS-1];

    // Next-state: capture in IDLE, walk c/w/h on each accepted beat in STREAM
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        w_d     = w_q;
        c_d     = c_q;
        drop_d  = 1'b0;
        cap_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    cap_en  = 1'b1;
                    h_d     = '0;
                    w_d     = '0;
                    c_d     = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                drop_d = valid_in;
                if (m_ready) begin
                    if (c_q == C_MAX) begin
                        c_d = '0;
                        if (w_q == W_MAX) begin
                            w_d = '0;
                            if (h_q == H_MAX) begin
                                h_d     = '0;
                                state_d = IDLE;
                            end else begin
                                h_d = h_q + HW'(1);
                            end
                        end else begin
                            w_d = w_q + WW'(1);
                        end
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and drop pulse; capture buffer is deliberately not reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            w_q     <= '0;
            c_q     <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            w_q     <= w_d;
            c_q     <= c_d;
            drop_q  <= drop_d;
        end
    end

    // Tensor capture buffer, written only when a frame is accepted
    always_ff @(posedge clk) begin
        if (cap_en) begin
            cap_q <= data_in;
        end
    end

    // Outputs decode from registered state only; zeroed while no beat is valid
    always_comb begin
        in_ready   = (state_q == IDLE);
        m_valid    = (state_q == STREAM);
        frame_drop = drop_q;
        m_data     = '0;
        m_first    = 1'b0;
        m_last     = 1'b0;
        if (m_valid) begin
            m_data  = cap_q[h_q][w_q][c_q];
            m_first = (h_q == '0) && (w_q == '0) && (c_q == '0);
            m_last  = (h_q == H_MAX) && (w_q == W_MAX) && (c_q == C_MAX);
        end
    end

`ifdef SER_EOL_EN
    // End-of-row marker on the last channel of the last pixel in each row
    always_comb begin
        m_eol = m_valid && (w_q == W_MAX) && (c_q == C_MAX);
    end
`endif

endmodule

// File: tb/tb_tensor_stream_serializer.sv
// Testbench for tensor_stream_serializer (2x2x2, 8-bit), queue-based
// reference model plus directed literal expectations.
module tb_tensor_stream_serializer;

    localparam int H  = 2;
    localparam int W  = 2;
    localparam int C  = 2;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 valid_in = 1'b0;
    logic signed [DW-1:0] data_in [0:H-1][0:W-1][0:C-1];
    logic                 in_ready;
    logic                 frame_drop;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic signed [DW-1:0] m_data;
    logic                 m_first;
    logic                 m_last;
`ifdef SER_EOL_EN
    logic                 m_eol;
`endif

    tensor_stream_serializer #(
        .CHANNELS  (C),
        .HEIGHT    (H),
        .WIDTH     (W),
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .frame_drop(frame_drop),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_first   (m_first),
        .m_last    (m_last)
`ifdef SER_EOL_EN
        ,
        .m_eol     (m_eol)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: a frame is a queue of expected beats
    typedef struct {
        int data;
        bit first;
        bit last;
        bit eol;
    } beat_t;

    beat_t exp_q[$];
    bit    exp_drop = 1'b0;

    // Observed accepted beats, for literal checks
    int log_d[$];
    bit log_f[$];
    bit log_l[$];
    bit log_e[$];
    int drops = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            exp_drop = 1'b0;
        end else begin
            bit busy;
            busy = (exp_q.size() != 0);
            if (m_valid && m_ready) begin
                log_d.push_back(int'(m_data));
                log_f.push_back(m_first);
                log_l.push_back(m_last);
`ifdef SER_EOL_EN
                log_e.push_back(m_eol);
`else
                log_e.push_back(1'b0);
`endif
            end
            if (frame_drop) drops++;
            exp_drop = valid_in && busy;
            if (busy && m_ready) begin
                void'(exp_q.pop_front());
            end else if (!busy && valid_in) begin
                for (int h = 0; h < H; h++)
                    for (int w = 0; w < W; w++)
                        for (int c = 0; c < C; c++) begin
                            beat_t b;
                            b.data  = int'(data_in[h][w][c]);
                            b.first = (h == 0 && w == 0 && c == 0);
                            b.last  = (h == H-1 && w == W-1 && c == C-1);
                            b.eol   = (w == W-1 && c == C-1);
                            exp_q.push_back(b);
                        end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        bit v;
        v = (exp_q.size() != 0);
        chk("m_valid", int'(m_valid), int'(v));
        chk("in_ready", int'(in_ready), int'(!v));
        chk("frame_drop", int'(frame_drop), int'(exp_drop));
        if (v) begin
            chk("m_data", int'(m_data), exp_q[0].data);
            chk("m_first", int'(m_first), int'(exp_q[0].first));
            chk("m_last", int'(m_last), int'(exp_q[0].last));
`ifdef SER_EOL_EN
            chk("m_eol", int'(m_eol), int'(exp_q[0].eol));
`endif
        end else begin
            chk("m_data_idle", int'(m_data), 0);
            chk("m_first_idle", int'(m_first), 0);
            chk("m_last_idle", int'(m_last), 0);
`ifdef SER_EOL_EN
            chk("m_eol_idle", int'(m_eol), 0);
`endif
        end
    end

    // mode 0: 1..8 raster, 1: all -5, 2: -128/127 alternating
    task automatic load(input int mode);
        for (int h = 0; h < H; h++)
            for (int w = 0; w < W; w++)
                for (int c = 0; c < C; c++) begin
                    int idx;
                    int v;
                    idx = h*W*C + w*C + c;
                    if (mode == 0) v = idx + 1;
                    else if (mode == 1) v = -5;
                    else v = (idx % 2 == 0) ? -128 : 127;
                    data_in[h][w][c] = DW'(v);
                end
    endtask

    task automatic clear_log();
        log_d.delete();
        log_f.delete();
        log_l.delete();
        log_e.delete();
    endtask

    task automatic pulse_frame();
        @(posedge clk);
        #1 valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        chk(name, int'(in_ready), 1);
    endtask

    task automatic chk_log(input string name, input int exp[8]);
        chk({name, "_count"}, log_d.size(), 8);
        if (log_d.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk({name, "_data"}, log_d[i], exp[i]);
                chk({name, "_first"}, int'(log_f[i]), int'(i == 0));
                chk({name, "_last"}, int'(log_l[i]), int'(i == 7));
            end
        end
    endtask

    initial begin
        int seq[8];
        int ext[8];
        seq = '{1, 2, 3, 4, 5, 6, 7, 8};
        ext = '{-128, 127, -128, 127, -128, 127, -128, 127};
        load(0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_frame_drop", int'(frame_drop), 0);
        rst = 1'b0;

        // Single frame, latency and closing idle cycle
        clear_log();
        pulse_frame();
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) begin
                chk("t1_valid", int'(m_valid), 1);
                chk("t1_busy", int'(in_ready), 0);
            end else begin
                chk("t1_ready_back", int'(in_ready), 1);
                chk("t1_valid_off", int'(m_valid), 0);
            end
        end
        chk_log("t1", seq);
`ifdef SER_EOL_EN
        for (int i = 0; i < 8; i++)
            chk("t1_eol", int'(log_e[i]), int'(i == 3 || i == 7));
`endif

        // Backpressure at beat 3 for 3 cycles
        clear_log();
        pulse_frame();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_hold_data", int'(m_data), 3);
            chk("t2_hold_valid", int'(m_valid), 1);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        wait_idle("t2_idle");
        chk_log("t2", seq);

        // Overlap drop during beat 4
        clear_log();
        drops = 0;
        pulse_frame();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        load(1);
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        chk("t3_drop_pulse", int'(frame_drop), 1);
        wait_idle("t3_idle");
        chk("t3_drop_count", drops, 1);
        chk_log("t3", seq);

        // Signed extremes
        clear_log();
        load(2);
        pulse_frame();
        wait_idle("t4_idle");
        chk_log("t4", ext);

        // Reset mid-stream at beat 5, then restart
        load(0);
        clear_log();
        pulse_frame();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("t5_pre_data", int'(m_data), 5);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", int'(m_valid), 0);
        chk("t5_rst_data", int'(m_data), 0);
        chk("t5_rst_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_log();
        pulse_frame();
        @(negedge clk);
        chk("t5_restart_first", int'(m_first), 1);
        chk("t5_restart_data", int'(m_data), 1);
        wait_idle("t5_idle");
        chk_log("t5", seq);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
